// File: rtl/fdiv_iter.sv
// Multi-cycle IEEE-754 single-precision divider, radix-2 restoring, fixed 28-edge latency.
// Define FDIV_ROUND_EN for round-to-nearest-even; otherwise the result is truncated.
module fdiv_iter (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {StIdle, StDiv, StNorm, StDone} state_e;

    state_e             state_q, state_d;
    logic               s_q;
    logic signed [9:0]  e_q;
    logic [24:0]        rem_q;
    logic [23:0]        d_q;
    logic               zflag_q, iflag_q;
    logic [4:0]         cnt_q;
    logic [25:0]        q_q;
    logic [31:0]        y_q;
    logic               out_valid_q;

    logic               ge;
    logic [24:0]        rem_sub;
    logic [22:0]        mant_t;
    logic               g, st;
    logic signed [9:0]  exp_t, exp_n;
    logic [23:0]        mant_r;
    logic [31:0]        y_n;
    logic signed [9:0]  e_in;

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = StDiv;
            StDiv:  if (cnt_q == 5'd25) state_d = StNorm;
            StNorm: state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        y         = y_q;
        out_valid = out_valid_q;
    end

    // Restoring step: rem stays below 2*d, so the shifted value fits in 25 bits.
    always_comb begin
        ge      = (rem_q >= {1'b0, d_q});
        rem_sub = ge ? (rem_q - {1'b0, d_q}) : rem_q;
        e_in    = $signed({2'b00, x1[30:23]}) - $signed({2'b00, x2[30:23]}) + 10'sd127;
    end

    always_comb begin
        if (q_q[25]) begin
            mant_t = q_q[24:2];
            g      = q_q[1];
            st     = q_q[0] | (rem_q != 25'd0);
            exp_t  = e_q;
        end else begin
            mant_t = q_q[23:1];
            g      = q_q[0];
            st     = (rem_q != 25'd0);
            exp_t  = e_q - 10'sd1;
        end
`ifdef FDIV_ROUND_EN
        mant_r = {1'b0, mant_t} + {23'd0, g & (st | mant_t[0])};
`else
        mant_r = {1'b0, mant_t};
`endif
        exp_n = mant_r[23] ? (exp_t + 10'sd1) : exp_t;
        if (zflag_q)               y_n = {s_q, 31'd0};
        else if (iflag_q)          y_n = {s_q, 8'hFF, 23'd0};
        else if (exp_n >= 10'sd255) y_n = {s_q, 8'hFF, 23'd0};
        else if (exp_n <= 10'sd0)  y_n = {s_q, 31'd0};
        else                       y_n = {s_q, exp_n[7:0], mant_r[22:0]};
    end

`ifndef FDIV_ROUND_EN
    logic unused_round;
    assign unused_round = g | st;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s_q         <= 1'b0;
            e_q         <= 10'sd0;
            rem_q       <= 25'd0;
            d_q         <= 24'd0;
            zflag_q     <= 1'b0;
            iflag_q     <= 1'b0;
            cnt_q       <= 5'd0;
            q_q         <= 26'd0;
            y_q         <= 32'd0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        s_q     <= x1[31] ^ x2[31];
                        e_q     <= e_in;
                        rem_q   <= {2'b01, x1[22:0]};
                        d_q     <= {1'b1, x2[22:0]};
                        zflag_q <= (x1[30:23] == 8'd0);
                        iflag_q <= (x2[30:23] == 8'd0) & (x1[30:23] != 8'd0);
                        cnt_q   <= 5'd0;
                        q_q     <= 26'd0;
                    end
                end
                StDiv: begin
                    q_q   <= {q_q[24:0], ge};
                    rem_q <= {rem_sub[23:0], 1'b0};
                    cnt_q <= cnt_q + 5'd1;
                end
                StNorm: begin
                    y_q         <= y_n;
                    out_valid_q <= 1'b1;
                end
                StDone: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fdiv_iter.md
# fdiv_iter

Multi-cycle IEEE-754 single-precision divider with valid/ready handshakes on both sides. It is the sequenced counterpart of the combinational `fdiv` datapath. The FPU issue stage drives operands in, and the result is returned to FPU writeback. It uses radix-2 restoring division and produces exactly one result per accepted request, with fixed latency. Special-case handling matches `fdiv`:

- Denormal inputs are flushed to zero.
- Underflowing results are flushed to zero.

## Interface
Parameters:
- none. Quotient width is fixed at 26 bits: 24 mantissa, 1 guard, 1 normalization bit.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstn`  in  1  synchronous reset, active-low.
- `x1`  in  32  dividend; sampled only on the accepting edge.
- `x2`  in  32  divisor; sampled only on the accepting edge.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  high only in IDLE. A request is accepted on an edge where `in_valid & in_ready`.
- `y`  out  32  quotient; registered and stable while `out_valid` is high.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts; the result is consumed on an edge where `out_valid & out_ready`.

## Operation
States are IDLE, DIV, NORM, DONE.

- **IDLE → DIV** on accept. Latch:
  - `s = x1[31]^x2[31]`
  - `e = x1[30:23] - x2[30:23] + 127`, 10-bit signed
  - `rem = {1'b0,1,x1[22:0]}` (25b)
  - `d = {1,x2[22:0]}`
  - `zflag = (x1[30:23]==0)`
  - `iflag = (x2[30:23]==0) & ~zflag`
  - `cnt = 0`
- **DIV**, one quotient bit per cycle:
  - If `rem >= d`, then `q bit = 1` and `rem -= d`; otherwise `q bit = 0`.
  - Then `rem <<= 1`, shift the bit into `q` from the LSB, and `cnt++`.
  - After 26 iterations, go to NORM.
- **NORM**:
  - If `q[25]`: `mant = q[24:2]`, `g = q[1]`, `st = q[0] | (rem!=0)`, exponent `e`.
  - Otherwise: `mant = q[23:1]`, `g = q[0]`, `st = (rem!=0)`, exponent `e-1`.
  - Apply rounding (see Configuration). If `mant` overflows to zero, increment the exponent.
  - Pack the result, in priority order:
    1. `zflag` → `{s,31'b0}`
    2. `iflag` → `{s,8'hFF,23'b0}`
    3. exponent ≥ 255 → `{s,8'hFF,23'b0}`
    4. exponent ≤ 0 → `{s,31'b0}`
    5. otherwise → `{s,exp[7:0],mant}`
  - Register `y`, set `out_valid`, go to DONE.
- **DONE**: hold `y` and `out_valid`. On `out_ready`, clear `out_valid` and go to IDLE.
- Inputs with exponent 255 (inf/NaN) are unsupported. The result value is don't-care, but the handshake and latency are unchanged.
- Special cases (`zflag`/`iflag`) still run all 26 iterations, so latency is data-independent.

## Timing
- **Reset:** `rstn` low at an edge forces IDLE. After that edge:
  - `out_valid = 0`, `y = 32'h0`, `in_ready = 1`
  - `cnt`, `q`, `rem` cleared
  - Any in-flight operation is discarded and never produces `out_valid`. This applies equally to a reset in DIV, NORM, or DONE.
- **Latency:** for an accepting edge E0:
  - E1..E26 perform the iterations.
  - E27 registers `y` and `out_valid`; the result is visible in the cycle after E27.
- **Throughput:** one operation outstanding at a time.
  - `in_ready` is low from E0 until the edge that consumes the result.
  - The earliest next accept is the edge after consumption.
- `in_valid` while busy is ignored, and operands are not re-sampled.
- `x1`/`x2` may change freely after E0.
- `out_ready` may be high before `out_valid`. In that case the result is consumed on the first edge with `out_valid` high, so DONE lasts exactly one cycle.
- `y` must not change while `out_valid & ~out_ready`.

## Configuration
- **`FDIV_ROUND_EN` defined:** round-to-nearest-even. Increment `mant` when `g & (st | mant[0])`.
- **`FDIV_ROUND_EN` undefined:** truncation. `g` and `st` are ignored, and the result is at most 1 ulp below exact.
- Latency is identical in both builds.

## Test plan
- **Exact division:** `x1=0x40C00000`, `x2=0x40000000` → `y=0x40400000`. `out_valid` is first seen in the cycle after E27, and `in_ready` is low over E0..E27.
- **Rounding (1/3):** `x1=0x3F800000`, `x2=0x40400000` → `y=0x3EAAAAAB` with `FDIV_ROUND_EN`, `0x3EAAAAAA` without.
- **Zero operands:**
  - `0x00000000 / 0xC0000000` → `0x80000000`
  - `0x3F800000 / 0x00000000` → `0x7F800000`
  - `0x00000000 / 0x00000000` → `0x00000000`
- **Range limits:**
  - Overflow: `0x7F000000 / 0x00800000` → `0x7F800000`
  - Underflow: `0x00800000 / 0x7F000000` → `0x00000000`
- **Backpressure:** hold `out_ready=0` for 10 cycles after `out_valid`.
  - `y` is stable and `in_ready` stays 0.
  - An `in_valid` pulse during this window is ignored.
  - Raise `out_ready` with a new request pending → the new request is accepted on the edge after consumption.
- **Reset mid-operation:** drive `rstn` low at iteration edge E10 for one cycle.
  - `out_valid` never rises for that request, and `in_ready=1` the cycle after the reset edge.
  - A new `6.0/2.0` request then returns `0x40400000` with normal latency.
